max_host_regs: RTL and testbench
================================

// Module: max_host_regs
// PURPOSE
//  CPLD-side responder for the FPGA->MAX host strobe bus (max_csn/max_wen/max_oen).
//  Sync'd strobes decode into a small register file; host reads config status, selects
//  flash image page and requests reconfiguration through a req/ack handshake to the
//  configuration sequencer. Clocked by clkin_max_100.
// PARAMETERS
//  ID_VALUE     16'hC1D0  read-only value at addr 0x0
//  SYNC_STAGES  2         flops per synchroniser on max_csn/max_wen/max_oen (>=2)
//  WDOG_W       24        watchdog counter width (HOST_WDOG_EN only)
// PORTS
//  clkin_max_100    in   1   system clock
//  sys_resetn       in   1   async active-low reset
//  max_csn          in   1   host chip select, active low, async
//  max_wen          in   1   host write strobe, active low, async
//  max_oen          in   1   host read strobe, active low, async
//  max_addr         in   4   register address, stable while max_csn low
//  max_din          in   16  write data, stable while max_wen low
//  max_dout         out  16  read data
//  max_dout_oe      out  1   read-data drive enable
//  fpga_conf_done   in   1   FPGA CONF_DONE (async, sync'd here)
//  fpga_statusn     in   1   FPGA nSTATUS (async, sync'd here)
//  cfg_page_active  in   2   page the sequencer last loaded
//  cfg_req          out  1   reconfiguration request, level, held until ack
//  cfg_page         out  2   page for requested reconfig, valid while cfg_req=1
//  cfg_ack          in   1   1-cycle pulse from sequencer: request taken
// BEHAVIOUR
//  Reset (async, sys_resetn=0): max_dout=0, max_dout_oe=0, cfg_req=0, cfg_page=0,
//   CTRL=0, SCRATCH=0, OVR=0, sync flops to 1 (strobes idle), FSM->IDLE.
//  Sync: csn/wen/oen through SYNC_STAGES flops + 1 edge flop; conf_done/statusn 2 flops.
//  Host must hold strobe low >= SYNC_STAGES+3 clocks; shorter pulses may be lost.
//  FSM IDLE: csn_s=0 & wen_s 1->0 -> WR; csn_s=0 & oen_s 1->0 -> RD; both same cycle -> WR.
//  WR (1 cycle): decode max_addr, capture max_din, apply write -> WAIT.
//  RD (1 cycle): max_dout<=reg[max_addr], max_dout_oe<=1 -> WAIT.
//  WAIT: stay until csn_s=1 or (wen_s=1 and oen_s=1); then max_dout_oe<=0 -> IDLE.
//   max_dout holds last read value. One access per strobe; no re-trigger inside WAIT.
//  Register map (unmapped: reads 16'h0000, writes ignored):
//   0x0 ID      RO  ID_VALUE
//   0x1 CTRL    RW  [2:1] page_sel, [0] go (write-1 self-clears, reads 0)
//   0x2 STATUS  RO  [0] conf_done_s [1] statusn_s [2] cfg_req [3] OVR
//                   [5:4] cfg_page_active [15:6] 0
//   0x3 SCRATCH RW  16-bit
//   0x4 OVRCLR  WO  write bit0=1 clears OVR
//   0x5 WDOG    WO  kick / timeout reload (HOST_WDOG_EN only; else unmapped)
//  Handshake: CTRL write go=1 with cfg_req=0 -> next cycle cfg_req=1, cfg_page=page_sel.
//   cfg_req drops cycle after cfg_ack=1; cfg_page holds. cfg_ack with cfg_req=0 ignored.
//   go=1 while cfg_req=1 (incl. same cycle as cfg_ack) -> page_sel still updates, no new
//   request, OVR set (sticky). OVR set and clear same cycle -> set wins.
//  Reset mid-request drops cfg_req at once; sequencer treats req fall as abort.
// CONFIGURATION
//  HOST_WDOG_EN defined: WDOG_W-bit down-counter, reload by WDOG write (value<<8,
//   0 disables). Counts only while fpga_conf_done_s=1 and cfg_req=0; at 1->0 raises
//   cfg_req with cfg_page=2'b00 (factory), STATUS[6]=1 until next WDOG write.
//   Counter stops (disabled) after firing. Reset: counter=0 (disabled).
//  Not defined: no counter, addr 0x5 unmapped, STATUS[6] reads 0.
// TESTING
//  Reset, read 0x0 (oen low 8 clk) -> max_dout=16'hC1D0, oe high during strobe, 0 after.
//  Write 0x3=16'hA55A, read 0x3 -> 16'hA55A; read 0x7 -> 16'h0000.
//  Write 0x1=16'h0005 -> cfg_req=1, cfg_page=2'b10 at WR+1; ack pulse -> cfg_req=0 next clk.
//  go while cfg_req=1, ack same cycle -> no new req, STATUS[3]=1; write 0x4=1 -> STATUS[3]=0.
//  Strobe held 2 clk -> no access; sys_resetn low while cfg_req=1 -> cfg_req=0 at once.
//  HOST_WDOG_EN: conf_done=1, WDOG=16'h0001, no kick -> cfg_req=1, page 2'b00 after 256 clk.

Source files
------------

// File: rtl/max_host_regs.sv
// Host strobe-bus register responder: synchronised csn/wen/oen decode into ID/CTRL/STATUS/SCRATCH/OVRCLR and a cfg req/ack handshake.
// Optional watchdog reconfiguration enabled by defining HOST_WDOG_EN.
module max_host_regs #(
    parameter logic [15:0] ID_VALUE    = 16'hC1D0,
    parameter int          SYNC_STAGES = 2,
    parameter int          WDOG_W      = 24
) (
    input  logic        clkin_max_100,
    input  logic        sys_resetn,
    input  logic        max_csn,
    input  logic        max_wen,
    input  logic        max_oen,
    input  logic [3:0]  max_addr,
    input  logic [15:0] max_din,
    output logic [15:0] max_dout,
    output logic        max_dout_oe,
    input  logic        fpga_conf_done,
    input  logic        fpga_statusn,
    input  logic [1:0]  cfg_page_active,
    output logic        cfg_req,
    output logic [1:0]  cfg_page,
    input  logic        cfg_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_WAIT} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] csn_sync, wen_sync, oen_sync;
    logic                   wen_d, oen_d;
    logic [1:0]             done_sync, statn_sync;
    logic                   csn_s, wen_s, oen_s, conf_done_s, statusn_s;
    logic                   wen_fall, oen_fall, wr_live, rd_live;
    logic                   wr_en, rd_en, wr_ctrl, go, ovr_set, ovr_clr;
    logic [1:0]             page_sel;
    logic [15:0]            scratch, rdata;
    logic                   ovr, wdog_flag, wdog_fire;

    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            csn_sync   <= '1;
            wen_sync   <= '1;
            oen_sync   <= '1;
            wen_d      <= 1'b1;
            oen_d      <= 1'b1;
            done_sync  <= '1;
            statn_sync <= '1;
        end else begin
            csn_sync   <= {csn_sync[SYNC_STAGES-2:0], max_csn};
            wen_sync   <= {wen_sync[SYNC_STAGES-2:0], max_wen};
            oen_sync   <= {oen_sync[SYNC_STAGES-2:0], max_oen};
            wen_d      <= wen_s;
            oen_d      <= oen_s;
            done_sync  <= {done_sync[0], fpga_conf_done};
            statn_sync <= {statn_sync[0], fpga_statusn};
        end
    end

    assign csn_s       = csn_sync[SYNC_STAGES-1];
    assign wen_s       = wen_sync[SYNC_STAGES-1];
    assign oen_s       = oen_sync[SYNC_STAGES-1];
    assign conf_done_s = done_sync[1];
    assign statusn_s   = statn_sync[1];
    assign wen_fall    = wen_d & ~wen_s;
    assign oen_fall    = oen_d & ~oen_s;
    // A strobe already released at the pin is dropped rather than acted on.
    assign wr_live     = (csn_sync == '0) && (wen_sync == '0);
    assign rd_live     = (csn_sync == '0) && (oen_sync == '0);

    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) state <= ST_IDLE;
        else             state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!csn_s && wen_fall)      next_state = ST_WR;
                else if (!csn_s && oen_fall) next_state = ST_RD;
            end
            ST_WR:   next_state = ST_WAIT;
            ST_RD:   next_state = ST_WAIT;
            ST_WAIT: if (csn_s || (wen_s && oen_s)) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    assign wr_en   = (state == ST_WR) && wr_live;
    assign rd_en   = (state == ST_RD) && rd_live;
    assign wr_ctrl = wr_en && (max_addr == 4'h1);
    assign go      = wr_ctrl && max_din[0];
    assign ovr_set = go && cfg_req;
    assign ovr_clr = wr_en && (max_addr == 4'h4) && max_din[0];

    always_comb begin
        rdata = 16'h0000;
        case (max_addr)
            4'h0: rdata = ID_VALUE;
            4'h1: rdata = {13'b0, page_sel, 1'b0};
            4'h2: rdata = {9'b0, wdog_flag, cfg_page_active, ovr, cfg_req, statusn_s, conf_done_s};
            4'h3: rdata = scratch;
            default: rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            max_dout    <= 16'h0000;
            max_dout_oe <= 1'b0;
        end else if (rd_en) begin
            max_dout    <= rdata;
            max_dout_oe <= 1'b1;
        end else if (state == ST_WAIT && next_state == ST_IDLE) begin
            max_dout_oe <= 1'b0;
        end
    end

    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            page_sel <= 2'b00;
            scratch  <= 16'h0000;
            ovr      <= 1'b0;
            cfg_req  <= 1'b0;
            cfg_page <= 2'b00;
        end else begin
            if (wr_ctrl) page_sel <= max_din[2:1];
            if (wr_en && (max_addr == 4'h3)) scratch <= max_din;
            ovr <= (ovr & ~ovr_clr) | ovr_set;
            if (cfg_req && cfg_ack) begin
                cfg_req <= 1'b0;
            end else if (go && !cfg_req) begin
                cfg_req  <= 1'b1;
                cfg_page <= max_din[2:1];
            end
            if (wdog_fire) begin
                cfg_req  <= 1'b1;
                cfg_page <= 2'b00;
            end
        end
    end

`ifdef HOST_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_wr;

    assign wdog_wr   = wr_en && (max_addr == 4'h5);
    assign wdog_fire = conf_done_s && !cfg_req && !wdog_wr && (wdog_cnt == WDOG_W'(1));

    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else if (wdog_wr) begin
            wdog_cnt  <= WDOG_W'({max_din, 8'h00});
            wdog_flag <= 1'b0;
        end else begin
            if (conf_done_s && !cfg_req && (wdog_cnt != '0)) wdog_cnt <= wdog_cnt - WDOG_W'(1);
            if (wdog_fire) wdog_flag <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_flag = 1'b0;
`endif

endmodule

// File: tb/tb_max_host_regs.sv
// Bench for max_host_regs: strobe-level host accesses compared against a register-map model.
module tb_max_host_regs;

    logic        clkin_max_100 = 1'b0;
    logic        sys_resetn = 1'b0;
    logic        max_csn = 1'b1, max_wen = 1'b1, max_oen = 1'b1;
    logic [3:0]  max_addr = 4'h0;
    logic [15:0] max_din = 16'h0000;
    logic [15:0] max_dout;
    logic        max_dout_oe;
    logic        fpga_conf_done = 1'b0, fpga_statusn = 1'b1;
    logic [1:0]  cfg_page_active = 2'b00;
    logic        cfg_req;
    logic [1:0]  cfg_page;
    logic        cfg_ack = 1'b0;

    int checks = 0;
    int fails  = 0;

    logic [15:0] m_scratch, m_last_rd;
    logic [1:0]  m_page_sel, m_page;
    logic        m_ovr, m_req, m_wdog;

    max_host_regs dut (
        .clkin_max_100(clkin_max_100), .sys_resetn(sys_resetn),
        .max_csn(max_csn), .max_wen(max_wen), .max_oen(max_oen),
        .max_addr(max_addr), .max_din(max_din),
        .max_dout(max_dout), .max_dout_oe(max_dout_oe),
        .fpga_conf_done(fpga_conf_done), .fpga_statusn(fpga_statusn),
        .cfg_page_active(cfg_page_active),
        .cfg_req(cfg_req), .cfg_page(cfg_page), .cfg_ack(cfg_ack)
    );

    always #5 clkin_max_100 = ~clkin_max_100;

    function automatic logic [15:0] exp_rd(input logic [3:0] a);
        case (a)
            4'h0: return 16'hC1D0;
            4'h1: return {13'b0, m_page_sel, 1'b0};
            4'h2: return {9'b0, m_wdog, cfg_page_active, m_ovr, m_req, fpga_statusn, fpga_conf_done};
            4'h3: return m_scratch;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_scratch = 0; m_last_rd = 0; m_page_sel = 0; m_page = 0;
        m_ovr = 0; m_req = 0; m_wdog = 0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [15:0] v, input logic ack_same);
        logic old_req;
        old_req = m_req;
        if (a == 4'h3) m_scratch = v;
        if (a == 4'h4 && v[0]) m_ovr = 0;
        if (a == 4'h1) begin
            m_page_sel = v[2:1];
            if (v[0] && old_req) m_ovr = 1;
            if (v[0] && !old_req) begin m_req = 1; m_page = v[2:1]; end
        end
        if (old_req && ack_same) m_req = 0;
    endtask

    task automatic host_read(input logic [3:0] a, input int hold,
                             output logic [15:0] d, output logic oe_seen, output logic oe_end);
        oe_seen = 0;
        @(negedge clkin_max_100);
        max_addr = a; max_csn = 0; max_oen = 0;
        repeat (hold) begin
            @(negedge clkin_max_100);
            if (max_dout_oe) oe_seen = 1;
        end
        max_csn = 1; max_oen = 1;
        repeat (6) @(negedge clkin_max_100);
        d = max_dout; oe_end = max_dout_oe;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] v, input int hold,
                              input int ack_at, output logic req3, output logic req4);
        req3 = 0; req4 = 0;
        @(negedge clkin_max_100);
        max_addr = a; max_din = v; max_csn = 0; max_wen = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clkin_max_100);
            if (i == 3) req3 = cfg_req;
            if (i == 4) req4 = cfg_req;
            if (ack_at != 0) cfg_ack = (i == ack_at);
        end
        cfg_ack = 0;
        max_csn = 1; max_wen = 1;
        repeat (6) @(negedge clkin_max_100);
    endtask

    task automatic check_read(input string name, input logic [3:0] a);
        logic [15:0] d, e;
        logic s, en;
        e = exp_rd(a);
        host_read(a, 8, d, s, en);
        m_last_rd = e;
        checks++;
        if (d !== e) begin fails++; $display("FAIL %s: addr %h got %h expected %h", name, a, d, e); end
    endtask

    task automatic check_req(input string name);
        checks++;
        if (cfg_req !== m_req || (m_req && cfg_page !== m_page)) begin
            fails++;
            $display("FAIL %s: cfg_req/page got %b/%b expected %b/%b", name, cfg_req, cfg_page, m_req, m_page);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clkin_max_100);
        checks++;
        if ({max_dout, max_dout_oe, cfg_req, cfg_page} !== 20'h0) begin
            fails++; $display("FAIL reset_outputs: got %h %b %b %b expected 0", max_dout, max_dout_oe, cfg_req, cfg_page);
        end
        sys_resetn = 1;
        repeat (3) @(negedge clkin_max_100);
        check_read("reset_ctrl", 4'h1);
        check_read("reset_scratch", 4'h3);
        check_read("reset_status", 4'h2);
    endtask

    task automatic test_id_read();
        logic [15:0] d;
        logic s, en;
        host_read(4'h0, 8, d, s, en);
        m_last_rd = 16'hC1D0;
        checks++;
        if (d !== 16'hC1D0) begin fails++; $display("FAIL id_read: got %h expected c1d0", d); end
        checks++;
        if (s !== 1'b1 || en !== 1'b0) begin fails++; $display("FAIL id_oe: during %b after %b expected 1 0", s, en); end
    endtask

    task automatic test_scratch_random();
        logic r3, r4;
        logic [3:0] a;
        logic [15:0] v;
        host_write(4'h3, 16'hA55A, 8, 0, r3, r4); model_write(4'h3, 16'hA55A, 0);
        check_read("scratch_a55a", 4'h3);
        check_read("unmapped_7", 4'h7);
        for (int n = 0; n < 12; n++) begin
            fpga_conf_done  = 1'($urandom);
            fpga_statusn    = 1'($urandom);
            cfg_page_active = 2'($urandom);
            v = 16'($urandom);
            case ($urandom_range(0, 2))
                0: begin host_write(4'h3, v, 8, 0, r3, r4); model_write(4'h3, v, 0); end
                1: begin v[0] = 0; host_write(4'h1, v, 8, 0, r3, r4); model_write(4'h1, v, 0); end
                default: ;
            endcase
            a = 4'($urandom);
            check_read("random_read", a);
        end
        fpga_conf_done = 0;
    endtask

    task automatic test_handshake();
        logic r3, r4;
        host_write(4'h1, 16'h0005, 8, 0, r3, r4); model_write(4'h1, 16'h0005, 0);
        checks++;
        if (r3 !== 1'b0 || r4 !== 1'b1) begin fails++; $display("FAIL req_latency: wr %b wr+1 %b expected 0 1", r3, r4); end
        check_req("req_page10");
        check_read("status_req", 4'h2);
        @(negedge clkin_max_100); cfg_ack = 1;
        @(negedge clkin_max_100); cfg_ack = 0;
        m_req = 0;
        check_req("ack_drop");
        checks++;
        if (cfg_page !== 2'b10) begin fails++; $display("FAIL page_hold: got %b expected 10", cfg_page); end
        @(negedge clkin_max_100); cfg_ack = 1;
        @(negedge clkin_max_100); cfg_ack = 0;
        check_req("stray_ack");
    endtask

    task automatic test_overrun();
        logic r3, r4;
        host_write(4'h1, 16'h0003, 8, 0, r3, r4); model_write(4'h1, 16'h0003, 0);
        check_req("req_page01");
        host_write(4'h1, 16'h0007, 8, 3, r3, r4); model_write(4'h1, 16'h0007, 1);
        check_req("go_with_ack");
        checks++;
        if (cfg_page !== 2'b01) begin fails++; $display("FAIL ovr_page_hold: got %b expected 01", cfg_page); end
        check_read("status_ovr", 4'h2);
        check_read("ctrl_after_ovr", 4'h1);
        host_write(4'h4, 16'h0001, 8, 0, r3, r4); model_write(4'h4, 16'h0001, 0);
        check_read("status_ovrclr", 4'h2);
    endtask

    task automatic test_short_strobe();
        logic r3, r4, s, en;
        logic [15:0] d;
        host_write(4'h3, 16'h1234, 2, 0, r3, r4);
        check_read("short_write", 4'h3);
        host_read(4'h0, 2, d, s, en);
        checks++;
        if (s !== 1'b0 || d !== m_last_rd) begin
            fails++; $display("FAIL short_read: oe %b dout %h expected 0 %h", s, d, m_last_rd);
        end
    endtask

    task automatic test_reset_mid_req();
        logic r3, r4;
        host_write(4'h1, 16'h0003, 8, 0, r3, r4); model_write(4'h1, 16'h0003, 0);
        check_req("req_before_reset");
        @(negedge clkin_max_100);
        #1 sys_resetn = 0;
        #1;
        checks++;
        if (cfg_req !== 1'b0 || cfg_page !== 2'b00) begin
            fails++; $display("FAIL reset_mid_req: got %b/%b expected 0/00", cfg_req, cfg_page);
        end
        model_reset();
        @(negedge clkin_max_100); sys_resetn = 1;
        repeat (3) @(negedge clkin_max_100);
        check_read("scratch_after_reset", 4'h3);
    endtask

    task automatic test_wdog();
        logic r3, r4;
`ifdef HOST_WDOG_EN
        fpga_conf_done = 1;
        repeat (4) @(negedge clkin_max_100);
        host_write(4'h5, 16'h0001, 8, 0, r3, r4);
        repeat (236) @(negedge clkin_max_100);
        check_req("wdog_early");
        repeat (12) @(negedge clkin_max_100);
        m_req = 1; m_page = 2'b00; m_wdog = 1;
        check_req("wdog_fire");
        check_read("status_wdog", 4'h2);
        @(negedge clkin_max_100); cfg_ack = 1;
        @(negedge clkin_max_100); cfg_ack = 0;
        m_req = 0;
        repeat (300) @(negedge clkin_max_100);
        check_req("wdog_stopped");
        fpga_conf_done = 0;
`else
        fpga_conf_done = 1;
        host_write(4'h5, 16'h0001, 8, 0, r3, r4);
        repeat (300) @(negedge clkin_max_100);
        check_req("no_wdog");
        check_read("status_no_wdog", 4'h2);
        check_read("addr5_unmapped", 4'h5);
        fpga_conf_done = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_scratch_random();
        test_handshake();
        test_overrun();
        test_short_strobe();
        test_reset_mid_req();
        test_wdog();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
